elite_spi_master: RTL and testbench
===================================

ELITE_SPI_MASTER -- requirements
Module: elite_spi_master

Interface
REQ-001 SHALL have parameter: HALF_PER, default 25, MClk cycles per SCLK half-period (50 MHz MClk -> 1 MHz SCLK); legal range 2..255.
REQ-002 SHALL have ports, one per line, in this order:
  MClk  input  1  system clock, 50 MHz; one clock, all logic on rising edge
  MSPI_Reset  input  1  reset, asynchronous, active-high
  MSPI_Start_Cmnd  input  1  1 = begin one byte transfer
  MSPI_Xmit_Data_Byte  input  8  byte to send, MSB first; valid with Start
  MSPI_Clk_Polarity  input  1  SCLK idle level (0 = mode 0, 1 = mode 3)
  MSPI_Ready_Flag  output  1  1 = idle, accepts Start; 0 = transfer in progress
  MSPI_Rcv_Data_Byte  output  8  last byte received from MISO
  MSPI_Done_Pulse  output  1  one-cycle pulse at transfer completion
  SPI_SCLK  output  1  serial clock to slave
  SPI_MOSI  output  1  serial data to slave
  SPI_MISO  input  1  serial data from slave, asynchronous
  SPI_CSEL  output  1  chip select, active low

Function
REQ-003 SHALL implement states IDLE, SETUP, XFER, HOLD, GAP.
REQ-004 IDLE: Ready=1, CSEL=1, SCLK=MSPI_Clk_Polarity (live), MOSI holds last value.
REQ-005 Start SHALL be sampled only in IDLE; Start in any other state SHALL be ignored (no queueing).
REQ-006 On the edge sampling Start=1 (cycle T): latch Xmit byte into shift register, latch polarity; at T+1 Ready=0, CSEL=0, MOSI=Xmit[7], state SETUP.
REQ-007 Half-period counter (8 bits) SHALL count HALF_PER cycles per phase; SETUP, HOLD, GAP each last exactly HALF_PER cycles.
REQ-008 XFER SHALL generate exactly 16 SCLK edges, one every HALF_PER cycles, first at T+1+HALF_PER, last at T+1+16*HALF_PER; SCLK returns to latched idle level after the 16th edge.
REQ-009 Data SHALL be sampled on every SCLK rising edge and shifted on every SCLK falling edge, independent of polarity.
REQ-010 Rising edge: shift synchronized MISO into receive register LSB, MSB first in.
REQ-011 Falling edge: MOSI <= next transmit bit; in mode 3 the first falling edge (before any rising edge) SHALL NOT shift; no shift after the 8th rising edge.
REQ-012 SPI_MISO SHALL pass through a 2-flop synchronizer; the value sampled is the synchronizer output at the MClk where SCLK rises.
REQ-013 HOLD: CSEL=0, SCLK idle; at T+1+17*HALF_PER CSEL=1, state GAP.
REQ-014 End of GAP (T+1+18*HALF_PER): Rcv_Data_Byte updated with the 8 received bits, Done=1 for one cycle, Ready=1, state IDLE; with HALF_PER=25 this is T+451.
REQ-015 Rcv_Data_Byte SHALL change only at REQ-014 completion; it holds between transfers.
REQ-016 Start high on the same cycle Ready returns to 1 SHALL NOT be accepted until the next cycle's sample (minimum CSEL-high gap = HALF_PER+1 cycles).
REQ-017 Polarity change during a transfer SHALL have no effect until return to IDLE.

Reset
REQ-018 MSPI_Reset=1 SHALL asynchronously force: state IDLE, Ready=1, CSEL=1, SCLK=1, MOSI=0, Done=0, Rcv_Data_Byte=0x00, counters and shift registers 0.
REQ-019 Reset mid-transfer SHALL abort immediately (CSEL=1 same cycle); partial received data SHALL be discarded; no Done pulse.
REQ-020 After reset deassertion, SCLK SHALL track MSPI_Clk_Polarity from the first clock edge.

Verification
REQ-021 Mode 0, Xmit=0xA5, slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 at rising edges; Rcv_Data_Byte=0x3C; Done at T+451.
REQ-022 Mode 3, Xmit=0x81, MISO loopback from MOSI -> 8 rising edges, SCLK idles high, Rcv_Data_Byte=0x81.
REQ-023 Start pulsed at T+100 during transfer -> ignored; exactly one Done, 16 SCLK edges.
REQ-024 Reset asserted at T+200 -> CSEL=1 and Ready=1 asynchronously, no Done, Rcv_Data_Byte=0x00.
REQ-025 Start held high continuously -> back-to-back transfers, CSEL high >= 26 cycles between, each 16 edges.
REQ-026 HALF_PER=2 build, Xmit=0xFF, MISO=0 -> Done at T+37, Rcv_Data_Byte=0x00.

Source files
------------

// File: rtl/elite_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// elite_spi_master: single-byte SPI master, modes 0/3, MSB first, fixed
// SETUP/XFER/HOLD/GAP framing of HALF_PER MClk cycles per phase.
// Revision: 1.0
// ---------------------------------------------------------------------------
module elite_spi_master #(
  parameter int unsigned HALF_PER = 25
) (
  input  logic       MClk,
  input  logic       MSPI_Reset,
  input  logic       MSPI_Start_Cmnd,
  input  logic [7:0] MSPI_Xmit_Data_Byte,
  input  logic       MSPI_Clk_Polarity,
  output logic       MSPI_Ready_Flag,
  output logic [7:0] MSPI_Rcv_Data_Byte,
  output logic       MSPI_Done_Pulse,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CSEL
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [7:0] HALF_LAST = 8'(HALF_PER - 1);

  logic [2:0] state, state_nxt;
  logic [7:0] half_cnt;
  logic [4:0] edge_cnt;
  logic [3:0] rise_cnt;
  logic [7:0] tx_sr, rx_sr, rcv_byte;
  logic       sclk_q, done_q, miso_s1, miso_s2;
  logic       phase_end, sclk_toggle;

  assign phase_end   = (half_cnt == HALF_LAST);
  assign sclk_toggle = phase_end && ((state == S_SETUP) || (state == S_XFER));

  always_ff @(posedge MClk or posedge MSPI_Reset) begin
    if (MSPI_Reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (MSPI_Start_Cmnd) state_nxt = S_SETUP;
      S_SETUP: if (phase_end) state_nxt = S_XFER;
      S_XFER:  if (phase_end && (edge_cnt == 5'd15)) state_nxt = S_HOLD;
      S_HOLD:  if (phase_end) state_nxt = S_GAP;
      S_GAP:   if (phase_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    MSPI_Ready_Flag = (state == S_IDLE);
    SPI_CSEL        = 1'b1;
    if ((state == S_SETUP) || (state == S_XFER) || (state == S_HOLD))
      SPI_CSEL = 1'b0;
  end

  assign SPI_SCLK           = sclk_q;
  assign SPI_MOSI           = tx_sr[7];
  assign MSPI_Rcv_Data_Byte = rcv_byte;
  assign MSPI_Done_Pulse    = done_q;

  always_ff @(posedge MClk or posedge MSPI_Reset) begin
    if (MSPI_Reset) begin
      half_cnt <= 8'd0;
      edge_cnt <= 5'd0;
      rise_cnt <= 4'd0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      rcv_byte <= 8'd0;
      sclk_q   <= 1'b1;
      done_q   <= 1'b0;
      miso_s1  <= 1'b0;
      miso_s2  <= 1'b0;
    end else begin
      miso_s1 <= SPI_MISO;
      miso_s2 <= miso_s1;
      done_q  <= 1'b0;
      if (state == S_IDLE) begin
        // Idle SCLK follows polarity; the value captured on the accept edge is the latched idle level.
        sclk_q   <= MSPI_Clk_Polarity;
        half_cnt <= 8'd0;
        edge_cnt <= 5'd0;
        rise_cnt <= 4'd0;
        if (MSPI_Start_Cmnd) begin
          tx_sr <= MSPI_Xmit_Data_Byte;
          rx_sr <= 8'd0;
        end
      end else begin
        half_cnt <= phase_end ? 8'd0 : half_cnt + 8'd1;
        if (sclk_toggle) begin
          sclk_q   <= ~sclk_q;
          edge_cnt <= edge_cnt + 5'd1;
          if (!sclk_q) begin
            rx_sr    <= {rx_sr[6:0], miso_s2};
            rise_cnt <= rise_cnt + 4'd1;
          end else if ((rise_cnt != 4'd0) && (rise_cnt != 4'd8)) begin
            // Falling edges before the first or after the last rising edge carry no new bit.
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
        if ((state == S_GAP) && phase_end) begin
          rcv_byte <= rx_sr;
          done_q   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_elite_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_elite_spi_master: directed scoreboard bench for elite_spi_master
// (HALF_PER=25 main instance, HALF_PER=2 secondary instance).
// ---------------------------------------------------------------------------
module tb_elite_spi_master;

  localparam int HP  = 25;
  localparam int HP2 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0, pol = 1'b0;
  logic [7:0] xmit = 8'h00;
  logic       ready, done, sclk, mosi, csel, miso;
  logic [7:0] rcv;

  logic       start2 = 1'b0, miso2 = 1'b0;
  logic [7:0] xmit2 = 8'h00;
  logic       ready2, done2, sclk2, mosi2, csel2;
  logic [7:0] rcv2;

  int checks = 0, failures = 0;
  logic [7:0] slave_byte = 8'h00;
  logic       loopback = 1'b0;
  int rise_total = 0, rise_base = 0, edge_total = 0, done_total = 0;
  int high_run = 0, last_gap = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] last_rcv = 8'h00;
  logic [7:0] exp_q[$];
  logic [2:0] sbit;

  elite_spi_master #(.HALF_PER(HP)) dut (
    .MClk(clk), .MSPI_Reset(rst), .MSPI_Start_Cmnd(start),
    .MSPI_Xmit_Data_Byte(xmit), .MSPI_Clk_Polarity(pol),
    .MSPI_Ready_Flag(ready), .MSPI_Rcv_Data_Byte(rcv), .MSPI_Done_Pulse(done),
    .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_CSEL(csel)
  );

  elite_spi_master #(.HALF_PER(HP2)) dut2 (
    .MClk(clk), .MSPI_Reset(rst), .MSPI_Start_Cmnd(start2),
    .MSPI_Xmit_Data_Byte(xmit2), .MSPI_Clk_Polarity(1'b0),
    .MSPI_Ready_Flag(ready2), .MSPI_Rcv_Data_Byte(rcv2), .MSPI_Done_Pulse(done2),
    .SPI_SCLK(sclk2), .SPI_MOSI(mosi2), .SPI_MISO(miso2), .SPI_CSEL(csel2)
  );

  always #10 clk = ~clk;

  // Slave presents the next MSB-first bit once the previous one has been sampled.
  assign sbit = 3'(7 - ((rise_total - rise_base) % 8));
  assign miso = loopback ? mosi : slave_byte[sbit];

  always @(posedge sclk) begin
    if (csel === 1'b0) begin
      rise_total <= rise_total + 1;
      mosi_cap   <= {mosi_cap[6:0], mosi};
    end
  end

  always @(sclk) begin
    if (csel === 1'b0) edge_total <= edge_total + 1;
  end

  always @(posedge clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
    if (csel === 1'b1) high_run <= high_run + 1;
    else if (high_run != 0) begin
      last_gap <= high_run;
      high_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One transfer on the main instance; 'disturb' injects a mid-transfer Start and polarity flip.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input logic md,
                      input logic lb, input bit disturb);
    int n, e0, d0;
    logic [7:0] want;
    slave_byte = sl;
    loopback   = lb;
    pol        = md;
    repeat (2) @(negedge clk);
    rise_base = rise_total;
    e0 = edge_total;
    d0 = done_total;
    exp_q.push_back(lb ? tx : sl);
    xmit  = tx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xmit  = 8'h00;
    chk("csel_low", csel, 0);
    chk("ready_low", ready, 0);
    chk("mosi_first", mosi, tx[7]);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      if (disturb && n == 100) start = 1'b1;
      if (disturb && n == 101) start = 1'b0;
      if (disturb && n == 150) pol = ~md;
      if (disturb && n == 200) chk("rcv_hold", rcv, last_rcv);
      @(negedge clk);
      n++;
    end
    // Done is seen one cycle after the accept edge plus 18 half periods.
    chk("latency", n, 18 * HP);
    want = exp_q.pop_front();
    chk("rcv_byte", rcv, want);
    last_rcv = want;
    chk("mosi_bits", mosi_cap, tx);
    chk("rise_count", rise_total - rise_base, 8);
    chk("edge_count", edge_total - e0, 16);
    chk("ready_back", ready, 1);
    chk("csel_idle", csel, 1);
    chk("sclk_idle", sclk, md);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("done_count", done_total - d0, 1);
  endtask

  initial begin
    int n, k, d0, e0;
    logic [7:0] want;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_csel", csel, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_done", done, 0);
    chk("rst_rcv", rcv, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("sclk_track_after_rst", sclk, 0);

    xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    xfer(8'h81, 8'h00, 1'b1, 1'b1, 1'b0);
    xfer(8'h6E, 8'h95, 1'b0, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    chk("no_queued_start", ready, 1);

    // Reset partway through a transfer.
    slave_byte = 8'hC3;
    loopback   = 1'b0;
    pol        = 1'b0;
    repeat (2) @(negedge clk);
    d0    = done_total;
    xmit  = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    chk("abort_csel_before", csel, 0);
    #5 rst = 1'b1;
    #1;
    chk("abort_csel", csel, 1);
    chk("abort_ready", ready, 1);
    chk("abort_sclk", sclk, 1);
    chk("abort_rcv", rcv, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_sclk_track", sclk, 0);
    repeat (500) @(negedge clk);
    chk("abort_no_done", done_total - d0, 0);
    chk("abort_rcv_after", rcv, 8'h00);

    // Start held high: two back-to-back transfers.
    slave_byte = 8'h96;
    repeat (2) @(negedge clk);
    rise_base = rise_total;
    e0 = edge_total;
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h96);
    xmit  = 8'h3C;
    start = 1'b1;
    k = 0;
    n = 0;
    while (k < 2 && n < 2000) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        want = exp_q.pop_front();
        chk("b2b_rcv", rcv, want);
        k++;
        if (k == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", k, 2);
    chk("b2b_csel_gap", last_gap, HP + 1);
    chk("b2b_edges", edge_total - e0, 32);
    chk("b2b_mosi_bits", mosi_cap, 8'h3C);
    repeat (5) @(negedge clk);
    chk("b2b_stopped", ready, 1);
    chk("queue_empty", exp_q.size(), 0);

    // HALF_PER=2 instance: 0xFF out, MISO low then high.
    for (int pass = 0; pass < 2; pass++) begin
      miso2 = (pass == 1);
      @(negedge clk);
      xmit2  = 8'hFF;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (done2 !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("hp2_latency", n, 18 * HP2);
      chk("hp2_rcv", rcv2, (pass == 1) ? 8'hFF : 8'h00);
      chk("hp2_ready", ready2, 1);
      chk("hp2_csel", csel2, 1);
      chk("hp2_sclk", sclk2, 0);
      chk("hp2_mosi_last", mosi2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
